// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forward-select encodings and the divider-stall FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-side bundle of the hazard controller: register addresses and
// stage flags in, stall/flush/forward controls and divider status out.
interface hazard_unit_if #(
  parameter int REG_ADDR_W = 5
) ();

  logic [REG_ADDR_W-1:0] Rs1D;
  logic [REG_ADDR_W-1:0] Rs2D;
  logic [REG_ADDR_W-1:0] Rs1E;
  logic [REG_ADDR_W-1:0] Rs2E;
  logic [REG_ADDR_W-1:0] RdE;
  logic [REG_ADDR_W-1:0] RdM;
  logic [REG_ADDR_W-1:0] RdW;
  logic                  LoadE;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic                  PCSrcE;
  logic                  DivStartE;

  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushM;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  DivBusy;
  logic                  DivDoneE;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output LoadE, RegWriteM, RegWriteW, PCSrcE, DivStartE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, DivBusy, DivDoneE
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  LoadE, RegWriteM, RegWriteW, PCSrcE, DivStartE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, DivBusy, DivDoneE
  );

endinterface

// File: rtl/div_stall_ctrl.sv
// Holds the pipeline while the iterative execute-stage divider runs.
// Built only when HAZARD_DIV_STALL_EN is defined.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no divide in flight; a DivStartE stalls this same cycle
//   BUSY  | divider iterating; cnt counts remaining stall cycles to 0
//   DONE  | result valid, execute advances at the end of this cycle
module div_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic CLK,
  input  logic RST,
  input  logic DivStartE,
  output logic divStall,
  output logic DivBusy,
  output logic DivDoneE
);

  localparam int              CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // DONE ignores DivStartE: the same divide is still sitting in execute.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (DivStartE) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign divStall = ((state == IDLE) && DivStartE) || (state == BUSY);
  assign DivBusy  = (state != IDLE);
  assign DivDoneE = (state == DONE);

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forwarding control for the 5-stage core.
// Divider stall FSM is included only when HAZARD_DIV_STALL_EN is defined.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic         CLK,
  input  logic         RST,
  hazard_unit_if.slave hz
);

  if (DIV_CYCLES < 2) begin : g_bad_div_cycles
    $error("hazard_unit: DIV_CYCLES must be >= 2");
  end

  logic lw_stall;
  logic div_stall;
  logic div_busy;
  logic div_done;
  logic stall_fd;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_w
  );
    if (we_m && (rd_m == rs) && (rd_m != '0))      return FWD_MEM;
    else if (we_w && (rd_w == rs) && (rd_w != '0)) return FWD_WB;
    else                                           return FWD_RF;
  endfunction

  always_comb begin
    hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  end

  assign lw_stall = hz.LoadE && (hz.RdE != REG_ADDR_W'(0)) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

`ifdef HAZARD_DIV_STALL_EN
  div_stall_ctrl #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_stall_ctrl (
    .CLK       (CLK),
    .RST       (RST),
    .DivStartE (hz.DivStartE),
    .divStall  (div_stall),
    .DivBusy   (div_busy),
    .DivDoneE  (div_done)
  );
`else
  logic unused_div_inputs;
  assign unused_div_inputs = &{1'b0, CLK, RST, hz.DivStartE};
  assign div_stall = 1'b0;
  assign div_busy  = 1'b0;
  assign div_done  = 1'b0;
`endif

  // A held decode register would swallow the clear, so a redirect beats the hold.
  assign stall_fd  = lw_stall || div_stall;
  assign hz.StallF = stall_fd;
  assign hz.StallD = stall_fd && !hz.PCSrcE;
  assign hz.FlushD = hz.PCSrcE;
  assign hz.FlushE = (lw_stall || hz.PCSrcE) && !div_stall;
  assign hz.StallE = div_stall;
  assign hz.FlushM = div_stall;

  assign hz.DivBusy  = div_busy;
  assign hz.DivDoneE = div_done;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table for the combinational
// paths plus divide and reset-mid-divide sequences, compared via a scoreboard.
module tb_hazard_unit;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  hazard_unit_if #(.REG_ADDR_W(5)) hz ();

  hazard_unit #(
    .DIV_CYCLES (4),
    .REG_ADDR_W (5)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz)
  );

`ifdef HAZARD_DIV_STALL_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    logic       sf, sd, se, fd, fe, fm;
    logic [1:0] fa, fb;
    logic       busy, done;
  } out_t;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       loade, rwm, rww, pcsrc, div, rst;
  } in_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  typedef struct {
    string name;
    out_t  o;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t expq[$];
  vec_t tbl[$];

  function automatic out_t mk(input logic sf, sd, se, fd, fe, fm,
                              input logic [1:0] fa, fb,
                              input logic busy, done);
    out_t o;
    o.sf = sf; o.sd = sd; o.se = se; o.fd = fd; o.fe = fe; o.fm = fm;
    o.fa = fa; o.fb = fb; o.busy = busy; o.done = done;
    return o;
  endfunction

  function automatic in_t mi(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                             input logic loade, rwm, rww, pcsrc, div, rst);
    in_t i;
    i.rs1d = rs1d; i.rs2d = rs2d; i.rs1e = rs1e; i.rs2e = rs2e;
    i.rde = rde; i.rdm = rdm; i.rdw = rdw;
    i.loade = loade; i.rwm = rwm; i.rww = rww; i.pcsrc = pcsrc;
    i.div = div; i.rst = rst;
    return i;
  endfunction

  task automatic add(input string name, input in_t i, input out_t o);
    vec_t v;
    v.name = name; v.i = i; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t i);
    hz.Rs1D = i.rs1d; hz.Rs2D = i.rs2d; hz.Rs1E = i.rs1e; hz.Rs2E = i.rs2e;
    hz.RdE = i.rde; hz.RdM = i.rdm; hz.RdW = i.rdw;
    hz.LoadE = i.loade; hz.RegWriteM = i.rwm; hz.RegWriteW = i.rww;
    hz.PCSrcE = i.pcsrc; hz.DivStartE = i.div;
    RST = i.rst;
  endtask

  function automatic out_t sample();
    return mk(hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
              hz.ForwardAE, hz.ForwardBE, hz.DivBusy, hz.DivDoneE);
  endfunction

  task automatic check_out();
    out_t act;
    exp_t e;
    act = sample();
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: actual=%b with no required value queued", act);
    end else begin
      e = expq.pop_front();
      if (act !== e.o) begin
        errors++;
        $display("FAIL %s: actual=%b required=%b (sf sd se fd fe fm fa fb busy done)",
                 e.name, act, e.o);
      end
    end
  endtask

  // Drive just after the rising edge, check on the falling edge.
  task automatic step(input string name, input in_t i, input out_t o);
    exp_t e;
    @(posedge CLK);
    #1;
    drive(i);
    e.name = name;
    e.o    = o;
    expq.push_back(e);
    @(negedge CLK);
    check_out();
  endtask

  localparam out_t O_ZERO = '0;

  out_t o_start, o_busy, o_busy_lw, o_done;
  in_t  i_start, i_idle, i_lw_div;

  initial begin
    drive(mi(0,0,0,0,0,0,0, 0,0,0,0,0,0));

    add("idle",             mi(0,0,0,0,0,0,0,    0,0,0,0,0,1), O_ZERO);
    add("fwd_mem_over_wb",  mi(0,0,5,0,0,5,5,    0,1,1,0,0,1), mk(0,0,0,0,0,0,2'b10,2'b00,0,0));
    add("fwd_wb",           mi(0,0,5,0,0,5,5,    0,0,1,0,0,1), mk(0,0,0,0,0,0,2'b01,2'b00,0,0));
    add("x0_mem",           mi(0,0,0,0,0,0,0,    0,1,0,0,0,1), O_ZERO);
    add("fwdB_mem_A_wb",    mi(0,0,3,9,0,9,3,    0,1,1,0,0,1), mk(0,0,0,0,0,0,2'b01,2'b10,0,0));
    add("no_regwrite",      mi(0,0,4,4,0,4,4,    0,0,0,0,0,1), O_ZERO);
    add("x0_wb",            mi(0,0,0,0,0,0,0,    0,0,1,0,0,1), O_ZERO);
    add("fwd_r31",          mi(0,0,31,31,0,31,0, 0,1,0,0,0,1), mk(0,0,0,0,0,0,2'b10,2'b10,0,0));
    add("fwd_split",        mi(0,0,5,6,0,6,5,    0,1,1,0,0,1), mk(0,0,0,0,0,0,2'b01,2'b10,0,0));
    add("lw_rs2",           mi(0,7,0,0,7,0,0,    1,0,0,0,0,1), mk(1,1,0,0,1,0,2'b00,2'b00,0,0));
    add("lw_drop",          mi(0,7,0,0,7,0,0,    0,0,0,0,0,1), O_ZERO);
    add("lw_rd0",           mi(0,0,0,0,0,0,0,    1,0,0,0,0,1), O_ZERO);
    add("lw_nomatch",       mi(6,5,0,0,7,0,0,    1,0,0,0,0,1), O_ZERO);
    add("lw_branch",        mi(3,0,0,0,3,0,0,    1,0,0,1,0,1), mk(1,0,0,1,1,0,2'b00,2'b00,0,0));
    add("branch_only",      mi(0,0,0,0,0,0,0,    0,0,0,1,0,1), mk(0,0,0,1,1,0,2'b00,2'b00,0,0));
    add("lw_rs1",           mi(12,0,0,0,12,0,0,  1,0,0,0,0,1), mk(1,1,0,0,1,0,2'b00,2'b00,0,0));

    step("reset_state", mi(0,0,0,0,0,0,0, 0,0,0,0,0,0), O_ZERO);

    foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].o);

    // Divide with DIV_CYCLES=4: 4 stalled cycles, then DONE with no stall.
    i_start  = mi(0,0,0,0,0,0,0, 0,0,0,0,1,1);
    i_idle   = mi(0,0,0,0,0,0,0, 0,0,0,0,0,1);
    i_lw_div = mi(0,7,0,0,7,0,0, 1,0,0,0,1,1);
    o_start   = DIV_EN ? mk(1,1,1,0,0,1,2'b00,2'b00,0,0) : O_ZERO;
    o_busy    = DIV_EN ? mk(1,1,1,0,0,1,2'b00,2'b00,1,0) : O_ZERO;
    o_busy_lw = DIV_EN ? mk(1,1,1,0,0,1,2'b00,2'b00,1,0)
                       : mk(1,1,0,0,1,0,2'b00,2'b00,0,0);
    o_done    = DIV_EN ? mk(0,0,0,0,0,0,2'b00,2'b00,1,1) : O_ZERO;

    step("div_start",      i_start,  o_start);
    step("div_busy1",      i_start,  o_busy);
    step("div_busy2_lw",   i_lw_div, o_busy_lw);
    step("div_busy3",      i_start,  o_busy);
    step("div_done",       i_start,  o_done);
    step("div_idle_after", i_idle,   O_ZERO);

    // Reset asserted in the second BUSY cycle, then a fresh full divide.
    step("rst_div_start",  i_start, o_start);
    step("rst_div_busy1",  i_idle,  o_busy);
    step("rst_mid_busy",   mi(0,0,0,0,0,0,0, 0,0,0,0,0,0), O_ZERO);
    step("rst_held",       mi(0,0,0,0,0,0,0, 0,0,0,0,0,0), O_ZERO);
    step("rst_new_start",  i_start, o_start);
    step("rst_new_busy1",  i_start, o_busy);
    step("rst_new_busy2",  i_start, o_busy);
    step("rst_new_busy3",  i_start, o_busy);
    step("rst_new_done",   i_start, o_done);
    step("rst_new_idle",   i_idle,  O_ZERO);

    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: actual=%0d entries required=0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage core. It drives the stall and flush inputs of the fetch, decode, execute and memory pipeline registers, including `StallD`/`FlushD` into the decode register. It also produces the execute-stage forwarding selects. A small FSM with a counter holds the pipeline while the iterative divider in the execute stage runs.

## Interface
Parameters:
- `DIV_CYCLES`, default 32: divider latency in cycles. Must be ≥ 2.
- `REG_ADDR_W`, default 5: register-address width.

Ports:
- `CLK`  in  1: rising-edge clock.
- `RST`  in  1: reset, asynchronous, active-low.
- `Rs1D`, `Rs2D`  in  REG_ADDR_W: source registers of the instruction in decode.
- `Rs1E`, `Rs2E`, `RdE`  in  REG_ADDR_W: source and destination registers in execute.
- `RdM`, `RdW`  in  REG_ADDR_W: destination registers in memory and writeback.
- `LoadE`  in  1: the instruction in execute is a load.
- `RegWriteM`, `RegWriteW`  in  1: the instruction in that stage writes the register file.
- `PCSrcE`  in  1: taken branch or jump resolved in execute.
- `DivStartE`  in  1: the instruction in execute is a divide.
- `StallF`, `StallD`, `StallE`  out  1: hold the PC register, the decode register and the execute register.
- `FlushD`, `FlushE`, `FlushM`  out  1: clear the decode, execute and memory registers to a bubble.
- `ForwardAE`, `ForwardBE`  out  2: operand source select for the execute stage.
- `DivBusy`  out  1: divider FSM is not idle.
- `DivDoneE`  out  1: the divider result is valid this cycle.

## Operation
- **Forwarding** (combinational): ForwardAE = `10` if RegWriteM & RdM==Rs1E & RdM!=0. Otherwise `01` if RegWriteW & RdW==Rs1E & RdW!=0. Otherwise `00`. ForwardBE follows the same rule using Rs2E. Memory stage wins over writeback. Register x0 is never forwarded.
- **Load-use stall**: lwStall = LoadE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- **Divider stall**: divStall = (state==IDLE & DivStartE) | state==BUSY.
- **Output equations**:
  - StallF = StallD = lwStall | divStall. StallD is forced to 0 whenever PCSrcE=1. Reason: the decode register ignores a clear while it is held, so a flush must win over a hold.
  - FlushD = PCSrcE.
  - FlushE = (lwStall | PCSrcE) & !divStall.
  - StallE = divStall.
  - FlushM = divStall. This inserts bubbles downstream while the divide instruction is held in execute.
- **Divider FSM states**: IDLE, BUSY, DONE.
  - IDLE, when DivStartE=1: load cnt = DIV_CYCLES-2 and go to BUSY.
  - BUSY: decrement cnt each cycle. When cnt==0, go to DONE.
  - DONE: go to IDLE unconditionally. DivStartE is ignored in DONE, because the same divide instruction is still in execute.
- **Status outputs**: DivBusy = state!=IDLE. DivDoneE = state==DONE.
- **Width rules**: cnt is $clog2(DIV_CYCLES) bits wide. It never underflows, because BUSY exits at 0.
- **Simultaneous events**:
  - PCSrcE and DivStartE cannot both be set; they would describe the same instruction. If both are set anyway, PCSrcE flushes decode and the divide still runs.
  - A load-use hazard during a divider stall is absorbed by the stall. It is re-evaluated after DONE.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the FSM state, and are valid in the same cycle.
- A divide occupies execute for DIV_CYCLES+1 cycles. StallE/StallD/StallF are high for exactly DIV_CYCLES cycles: the IDLE start cycle plus DIV_CYCLES-1 BUSY cycles. The DONE cycle is unstalled, and execute advances at the end of DONE.
- A load-use hazard gives exactly a 1-cycle stall plus a 1-cycle execute bubble.
- Reset (RST=0 at any time, including mid-BUSY) forces state=IDLE and cnt=0. All registered state clears immediately. The stall and flush outputs then follow the combinational equations with state=IDLE.

## Configuration
- `HAZARD_DIV_STALL_EN` defined:
  - The divider FSM and counter are built as described.
- `HAZARD_DIV_STALL_EN` undefined:
  - No FSM and no counter; divStall=0.
  - DivBusy=0 and DivDoneE=0.
  - DivStartE is ignored.
  - The block is purely combinational apart from the unused CLK/RST, and the port list is unchanged.

## Structure
- Package `hazard_pkg` holds:
  - Forward-select constants: `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10.
  - The divider state typedef: IDLE/BUSY/DONE.
- Sub-module `div_stall_ctrl` holds the FSM and counter. It takes CLK, RST and DivStartE, and outputs divStall, DivBusy and DivDoneE. It is instantiated only under the macro.

## Test plan
- **Forwarding, memory over writeback**: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=`10`. Then RegWriteM=0 -> ForwardAE=`01`.
- **x0 never forwarded**: Rs2E=0, RdM=0, RegWriteM=1 -> ForwardBE=`00`.
- **Load-use stall**: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Drop LoadE -> all outputs 0.
- **Branch during load-use**: LoadE=1, RdE=3, Rs1D=3, PCSrcE=1 -> StallD=0, FlushD=1, FlushE=1.
- **Divide, DIV_CYCLES=4**: DivStartE held high -> StallE high for 4 cycles and DivDoneE=1 in cycle 5 with no stall. There is no restart while DivStartE stays high through DONE. After that DivBusy=0.
- **Reset mid-divide**: assert RST=0 in the 2nd BUSY cycle with DivStartE=0 -> DivBusy=0 and StallE=0 immediately. After reset is released, a new DivStartE yields a full 4-cycle stall.
